sub_unit: RTL and testbench
===========================

Name: sub_unit

Overview:
- Registered two-operand integer subtractor: Z = A - B, with status flags.
- Used as a simple ALU slice in the datapath.
- Combinational difference core followed by one output register stage, with a valid strobe and an optional saturating mode.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).
- SAT_EN, 1, 1 = saturating modes available; 0 = mode input ignored and treated as wrap.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- in_valid  input  1  operands valid this cycle.
- mode  input  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 reserved (treated as wrap).
- Z  output  WIDTH  registered result.
- out_valid  output  1  Z and flags valid; asserted one cycle after the accepted in_valid.
- borrow  output  1  unsigned borrow: A < B as unsigned.
- zero  output  1  Z == 0 after any saturation.
- neg  output  1  Z[WIDTH-1].
- ovf  output  1  signed two's-complement overflow of the raw difference.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Both are fixed.
- Reset:
  - On a rising clk edge with rst=1, all outputs become 0 (Z, out_valid, borrow, zero, neg, ovf).
  - rst has priority over in_valid in the same cycle; any in-flight result is discarded.
- Latency: one cycle. Operands sampled at edge N with in_valid=1 appear on outputs after edge N, with out_valid=1.
- Throughput: one operation per cycle; no backpressure.
- When in_valid=0:
  - out_valid deasserts on the next edge.
  - Z and the flags hold their previous values.
- Raw difference:
  - D = A - B computed in WIDTH+1 bits.
  - borrow = D[WIDTH].
  - ovf = (A[msb] != B[msb]) && (D[msb] != A[msb]).
- Wrap mode (00 or 11): Z = D[WIDTH-1:0], modulo 2^WIDTH.
- Unsigned saturate (01): if borrow, Z = 0; else Z = D.
- Signed saturate (10):
  - If ovf and A[msb]=0, Z = 2^(WIDTH-1)-1 (0x7F for WIDTH 8).
  - If ovf and A[msb]=1, Z = 2^(WIDTH-1) (0x80).
  - Otherwise Z = D.
- borrow and ovf always report the raw difference, regardless of mode.
- zero and neg are derived from the final Z.
- A == B gives Z=0, zero=1, borrow=0, ovf=0 in every mode.
- X-free: every register has a defined reset value; no latches.

Decomposition:
- Shared package sub_pkg:
  - WIDTH default constant.
  - mode enum (MODE_WRAP, MODE_USAT, MODE_SSAT, MODE_RSVD).
  - flag struct {borrow, zero, neg, ovf}.
- Sub-module sub_core: purely combinational. Takes A, B, mode; produces the final Z and flags.
- sub_unit wraps sub_core with the output register and the valid pipeline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> all outputs 0, out_valid=0. Then release rst.
- Basic wrap: A=255, B=127, mode=00, in_valid=1 -> next cycle Z=128 (0x80), borrow=0, neg=1, ovf=0, zero=0, out_valid=1.
- Unsigned borrow: A=10, B=20, mode=00 -> Z=246, borrow=1. Same operands with mode=01 -> Z=0, zero=1, borrow=1.
- Signed overflow: A=0x80, B=0x01, mode=00 -> Z=0x7F, ovf=1. With mode=10 -> Z=0x80, ovf=1, neg=1.
- Positive overflow: A=0x7F, B=0xFF, mode=10 -> Z=0x7F, ovf=1, borrow=1.
- Back-to-back and hold:
  - Three consecutive valid operations (5-3, 3-5, 0-0) -> results 2, 254, 0 on three consecutive cycles.
  - Then in_valid=0 -> out_valid=0, Z holds 0.
  - Asserting rst mid-stream clears outputs on the next edge.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the registered subtractor slice.
//   WIDTH_DEF : default operand/result width
//   mode_t    : result shaping mode (wrap, unsigned saturate, signed saturate, reserved)
//   flags_t   : status flags produced alongside the difference
package sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_USAT = 2'b01,
    MODE_SSAT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef struct packed {
    logic borrow;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/sub_core.sv
// Combinational subtract core: z = a - b with optional saturation and flags.
// Ports:
//   a, b  : minuend / subtrahend, WIDTH bits
//   mode  : 00 wrap, 01 unsigned saturate, 10 signed saturate, 11 wrap
//   z     : final (possibly saturated) difference
//   flags : borrow/ovf from the raw difference, zero/neg from final z
module sub_core
  import sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] z,
  output flags_t           flags
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] diff;
  logic           raw_borrow;
  logic           raw_ovf;
  mode_t          eff_mode;

  // The extra top bit of the widened difference is the unsigned borrow.
  // Signed overflow happens only when the operand signs differ and the
  // result sign disagrees with the minuend.
  always_comb begin
    diff       = {1'b0, a} - {1'b0, b};
    raw_borrow = diff[WIDTH];
    raw_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    eff_mode   = SAT_EN ? mode_t'(mode) : MODE_WRAP;

    z = diff[WIDTH-1:0];
    case (eff_mode)
      MODE_USAT: if (raw_borrow) z = '0;
      MODE_SSAT: if (raw_ovf) z = a[WIDTH-1] ? SMIN : SMAX;
      default:   z = diff[WIDTH-1:0];
    endcase

    flags.borrow = raw_borrow;
    flags.ovf    = raw_ovf;
    flags.zero   = (z == '0);
    flags.neg    = z[WIDTH-1];
  end

endmodule

// File: rtl/sub_unit.sv
// Registered subtractor ALU slice: one-cycle latency, one op per cycle.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   A, B       : operands; in_valid qualifies them
//   mode       : result mode (see sub_core)
//   Z          : registered result, holds when no new operation is accepted
//   out_valid  : high the cycle after an accepted in_valid
//   borrow, zero, neg, ovf : registered status flags, held together with Z
module sub_unit
  import sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] Z,
  output logic             out_valid,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic [WIDTH-1:0] core_z;
  flags_t           core_flags;

  sub_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .a     (A),
    .b     (B),
    .mode  (mode),
    .z     (core_z),
    .flags (core_flags)
  );

  // Result and flags only load on accepted operations so they hold while
  // idle; the valid strobe simply follows in_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Z         <= '0;
      out_valid <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z      <= core_z;
        borrow <= core_flags.borrow;
        zero   <= core_flags.zero;
        neg    <= core_flags.neg;
        ovf    <= core_flags.ovf;
      end
    end
  end

endmodule

// File: tb/tb_sub_unit.sv
// Self-checking bench for sub_unit (WIDTH=8, SAT_EN=1).
// Expected results come from an integer reference model and travel through
// a scoreboard queue from the stimulus side to the output check.
module tb_sub_unit;

  typedef struct packed {
    logic [7:0] z;
    logic       borrow;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] Z;
  logic       out_valid, borrow, zero, neg, ovf;

  exp_t expq[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  sub_unit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .mode      (mode),
    .Z         (Z),
    .out_valid (out_valid),
    .borrow    (borrow),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference model using plain integer arithmetic on signed/unsigned views.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    exp_t e;
    int ud, sd;
    logic [7:0] wrap;
    ud   = int'(a) - int'(b);
    sd   = int'($signed(a)) - int'($signed(b));
    wrap = 8'((ud + 256) % 256);
    e.borrow = (ud < 0);
    e.ovf    = (sd > 127) || (sd < -128);
    case (m)
      2'b01:   e.z = e.borrow ? 8'h00 : wrap;
      2'b10:   e.z = (sd > 127) ? 8'h7F : ((sd < -128) ? 8'h80 : wrap);
      default: e.z = wrap;
    endcase
    e.zero = (e.z == 8'h00);
    e.neg  = (e.z >= 8'h80);
    return e;
  endfunction

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one valid operation and record its expected result.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    A = a; B = b; mode = m; in_valid = 1'b1;
    expq.push_back(model(a, b, m));
  endtask

  task automatic checkAll(input string tag, input exp_t e, input logic v);
    checkField({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, v});
    checkField({tag, ".Z"},         Z,                 e.z);
    checkField({tag, ".borrow"},    {7'b0, borrow},    {7'b0, e.borrow});
    checkField({tag, ".zero"},      {7'b0, zero},      {7'b0, e.zero});
    checkField({tag, ".neg"},       {7'b0, neg},       {7'b0, e.neg});
    checkField({tag, ".ovf"},       {7'b0, ovf},       {7'b0, e.ovf});
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    vectors++;
    assert (expq.size() != 0) else begin
      miscompares++;
      $error("[TB] FAIL %s.scoreboard: observed 0 entries expected 1", tag);
    end
    if (expq.size() != 0) begin
      e = expq.pop_front();
      checkAll(tag, e, 1'b1);
      last_exp = e;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t zero_exp;
    logic [7:0] ra, rb;
    logic [1:0] rm;
    zero_exp = '0;

    // Reset with in_valid high: outputs must stay cleared.
    rst = 1'b1; A = 8'hAA; B = 8'h11; in_valid = 1'b1;
    tick();
    tick();
    checkAll("reset", zero_exp, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    applyStimulus(8'd255, 8'd127, 2'b00); tick(); checkOutput("wrap_255_127");
    applyStimulus(8'd10,  8'd20,  2'b00); tick(); checkOutput("wrap_borrow");
    applyStimulus(8'd10,  8'd20,  2'b01); tick(); checkOutput("usat_borrow");
    applyStimulus(8'h80,  8'h01,  2'b00); tick(); checkOutput("wrap_negovf");
    applyStimulus(8'h80,  8'h01,  2'b10); tick(); checkOutput("ssat_negovf");
    applyStimulus(8'h7F,  8'hFF,  2'b10); tick(); checkOutput("ssat_posovf");
    applyStimulus(8'h7F,  8'hFF,  2'b11); tick(); checkOutput("rsvd_wrap");
    applyStimulus(8'h40,  8'h10,  2'b01); tick(); checkOutput("usat_nosat");
    for (int m = 0; m < 4; m++) begin
      applyStimulus(8'h5C, 8'h5C, 2'(m)); tick(); checkOutput("equal_ops");
    end

    // Back-to-back operations on consecutive cycles.
    applyStimulus(8'd5, 8'd3, 2'b00); tick(); checkOutput("b2b_0");
    applyStimulus(8'd3, 8'd5, 2'b00); tick(); checkOutput("b2b_1");
    applyStimulus(8'd0, 8'd0, 2'b00); tick(); checkOutput("b2b_2");

    // Idle: valid drops, result and flags hold even with new operand values.
    in_valid = 1'b0; A = 8'h12; B = 8'h34; mode = 2'b10;
    tick();
    checkAll("hold_0", last_exp, 1'b0);
    tick();
    checkAll("hold_1", last_exp, 1'b0);

    // Random operations across all modes.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      applyStimulus(ra, rb, rm); tick(); checkOutput("random");
    end

    // Reset mid-stream: in-flight operation is discarded.
    applyStimulus(8'hF0, 8'h01, 2'b00); tick(); checkOutput("pre_reset");
    rst = 1'b1; A = 8'h90; B = 8'h10; mode = 2'b00; in_valid = 1'b1;
    tick();
    checkAll("mid_reset", zero_exp, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checkAll("post_reset_idle", zero_exp, 1'b0);

    vectors++;
    assert (expq.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
